// File: rtl/csignal_post_queue_pkg.sv
// csignal_post_queue_pkg: shared FSM state encodings and default sizes for the signal post queue
package csignal_post_queue_pkg;

    localparam int CSPQ_DATAWIDTH = 8;
    localparam int CSPQ_DEPTH     = 4;
    localparam int CSPQ_ADDRWIDTH = 2;

    // Encoding 2'd3 is unused; the FSM recovers from it to CSPQ_IDLE.
    typedef enum logic [1:0] {
        CSPQ_IDLE  = 2'd0,
        CSPQ_PULSE = 2'd1,
        CSPQ_HOLD  = 2'd2
    } cspq_state_e;

endpackage

// File: rtl/csignal_post_fifo.sv
// csignal_post_fifo: FIFO storage for posted values with occupancy count and sticky overflow
//  clk        in   rising-edge clock
//  reset      in   synchronous, active-high; empties the queue and clears overflow
//  push_en    in   producer push request; dropped when full
//  push_data  in   value to store
//  pop_en     in   remove the head entry (ignored when empty)
//  head_data  out  value at the head of the queue
//  count      out  entries queued (0..depth), registered
//  full       out  count == depth
//  empty      out  count == 0
//  overflow   out  sticky: a push arrived while full
module csignal_post_fifo #(
    parameter int datawidth = 8,
    parameter int depth     = 4,
    parameter int addrwidth = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_en,
    input  logic [datawidth-1:0] push_data,
    input  logic                 pop_en,
    output logic [datawidth-1:0] head_data,
    output logic [addrwidth:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    logic [datawidth-1:0] mem [depth];
    logic [addrwidth-1:0] wr_ptr;
    logic [addrwidth-1:0] rd_ptr;
    logic                 push;
    logic                 pop;

    assign full      = count == (addrwidth+1)'(depth);
    assign empty     = count == '0;
    assign push      = push_en && !full;
    assign pop       = pop_en && !empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (addrwidth+1)'(push) - (addrwidth+1)'(pop);
            overflow <= overflow || (push_en && full);
        end
    end

endmodule

// File: rtl/csignal_post_queue.sv
// csignal_post_queue: buffers producer posts and feeds them one at a time to a signal's input_en/input_data
//  clk             in   rising-edge clock
//  reset           in   synchronous, active-high
//  post_en         in   producer posts post_data this cycle (accepted when post_rdy=1)
//  post_data       in   value to post
//  post_rdy        out  queue not full
//  sig_input_en    out  registered one-cycle pulse to the signal's input_en
//  sig_input_data  out  registered value, valid with sig_input_en and held afterwards
//  sig_output_rdy  in   signal's "signaled" flag
//  pending         out  entries currently queued
//  overflow        out  sticky: a post arrived while full
module csignal_post_queue
    import csignal_post_queue_pkg::*;
#(
    parameter int datawidth = CSPQ_DATAWIDTH,
    parameter int depth     = CSPQ_DEPTH,
    parameter int addrwidth = CSPQ_ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 post_en,
    input  logic [datawidth-1:0] post_data,
    output logic                 post_rdy,
    output logic                 sig_input_en,
    output logic [datawidth-1:0] sig_input_data,
    input  logic                 sig_output_rdy,
    output logic [addrwidth:0]   pending,
    output logic                 overflow
);

    cspq_state_e          state;
    cspq_state_e          next_state;
    logic                 load;
    logic [datawidth-1:0] head_data;
    logic                 full;
    logic                 empty;

    csignal_post_fifo #(
        .datawidth (datawidth),
        .depth     (depth),
        .addrwidth (addrwidth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_en   (post_en),
        .push_data (post_data),
        .pop_en    (load),
        .head_data (head_data),
        .count     (pending),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= CSPQ_IDLE;
        else
            state <= next_state;
    end

    // A high sig_output_rdy means a value (ours or a foreign poster's) is still
    // unconsumed, so a new pulse waits until it drops. The first HOLD cycle
    // seeing it low is taken as consumed (signal was reset externally).
    always_comb begin
        next_state = CSPQ_IDLE;
        case (state)
            CSPQ_IDLE:  next_state = (!empty && !sig_output_rdy) ? CSPQ_PULSE : CSPQ_IDLE;
            CSPQ_PULSE: next_state = CSPQ_HOLD;
            CSPQ_HOLD:  next_state = sig_output_rdy ? CSPQ_HOLD : (!empty ? CSPQ_PULSE : CSPQ_IDLE);
            default:    next_state = CSPQ_IDLE;
        endcase
    end

    // Entering PULSE pops the head into the output register in the same edge.
    always_comb begin
        load     = next_state == CSPQ_PULSE;
        post_rdy = !full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_input_en   <= 1'b0;
            sig_input_data <= '0;
        end else begin
            sig_input_en <= load;
            if (load)
                sig_input_data <= head_data;
        end
    end

endmodule

// File: tb/tb_csignal_post_queue.sv
// tb_csignal_post_queue: directed scoreboard bench for csignal_post_queue with a behavioural signal/consumer model
module tb_csignal_post_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       post_en = 1'b0;
    logic [7:0] post_data = 8'h00;
    logic       post_rdy;
    logic       sig_input_en;
    logic [7:0] sig_input_data;
    logic       sig_output_rdy;
    logic [2:0] pending;
    logic       overflow;

    logic       signaled = 1'b0;
    logic       foreign = 1'b0;
    logic       stall = 1'b0;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         pulses = 0;
    int         checks = 0;
    int         passed = 0;
    int         p0;
    logic [7:0] exp_q[$];

    csignal_post_queue dut (
        .clk            (clk),
        .reset          (reset),
        .post_en        (post_en),
        .post_data      (post_data),
        .post_rdy       (post_rdy),
        .sig_input_en   (sig_input_en),
        .sig_input_data (sig_input_data),
        .sig_output_rdy (sig_output_rdy),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    assign sig_output_rdy = signaled | foreign;

    // Signal + consumer: signaled rises the cycle after input_en, consumer
    // reads ack_delay cycles later (unless stalled) and signaled falls.
    always @(posedge clk) begin
        if (reset) begin
            signaled <= 1'b0;
            wait_cnt <= 0;
        end else if (sig_input_en) begin
            signaled <= 1'b1;
            wait_cnt <= 0;
        end else if (signaled && !stall) begin
            if (wait_cnt >= ack_delay)
                signaled <= 1'b0;
            else
                wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every delivered pulse must match the oldest expected post.
    always @(negedge clk) begin
        if (!reset && sig_input_en) begin
            pulses++;
            check("pulse_while_signaled", int'(sig_output_rdy), 0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: got data %0h expected no pulse", sig_input_data);
            end else begin
                check("delivered_data", int'(sig_input_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic [7:0] v, input bit accept);
        post_en   = 1'b1;
        post_data = v;
        if (accept)
            exp_q.push_back(v);
        tick;
        post_en = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick;
        check("drain_scoreboard_empty", exp_q.size(), 0);
        check("drain_pending", int'(pending), 0);
    endtask

    initial begin
        repeat (3) tick;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_post_rdy", int'(post_rdy), 1);
            check("idle_pending", int'(pending), 0);
            check("idle_input_en", int'(sig_input_en), 0);
            check("idle_overflow", int'(overflow), 0);
        end

        post(8'hA5, 1'b1);
        check("lat_t1_input_en", int'(sig_input_en), 0);
        check("lat_t1_pending", int'(pending), 1);
        tick;
        check("lat_t2_input_en", int'(sig_input_en), 1);
        check("lat_t2_data", int'(sig_input_data), 'hA5);
        check("lat_t2_pending", int'(pending), 0);
        tick;
        check("lat_t3_input_en", int'(sig_input_en), 0);
        check("lat_t3_data_held", int'(sig_input_data), 'hA5);
        drain(20);

        ack_delay = 5;
        p0 = pulses;
        for (int i = 1; i <= 4; i++) begin
            check("b2b_post_rdy", int'(post_rdy), 1);
            post(8'(i), 1'b1);
        end
        drain(60);
        check("b2b_pulse_count", pulses - p0, 4);

        ack_delay = 0;
        foreign = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            check("fill_post_rdy", int'(post_rdy), 1);
            post(8'h10 + 8'(i), 1'b1);
        end
        check("full_pending", int'(pending), 4);
        check("full_post_rdy", int'(post_rdy), 0);
        check("full_overflow_before", int'(overflow), 0);
        post(8'hFF, 1'b0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_pending", int'(pending), 4);
        tick;
        check("ovf_sticky", int'(overflow), 1);
        p0 = pulses;
        foreign = 1'b0;
        drain(30);
        check("ovf_release_count", pulses - p0, 4);
        check("ovf_still_set", int'(overflow), 1);

        foreign = 1'b1;
        tick;
        post(8'h55, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick;
            check("foreign_blocked_en", int'(sig_input_en), 0);
            check("foreign_blocked_pending", int'(pending), 1);
        end
        foreign = 1'b0;
        check("foreign_drop_en", int'(sig_input_en), 0);
        tick;
        check("foreign_release_en", int'(sig_input_en), 1);
        check("foreign_release_data", int'(sig_input_data), 'h55);
        drain(20);

        stall = 1'b1;
        post(8'hC1, 1'b1);
        post(8'hC2, 1'b0);
        post(8'hC3, 1'b0);
        post(8'hC4, 1'b0);
        repeat (3) tick;
        check("hold_pending", int'(pending), 3);
        check("hold_input_en", int'(sig_input_en), 0);
        check("hold_signaled", int'(sig_output_rdy), 1);
        check("hold_overflow", int'(overflow), 1);
        reset = 1'b1;
        tick;
        check("rst_pending", int'(pending), 0);
        check("rst_input_en", int'(sig_input_en), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_post_rdy", int'(post_rdy), 1);
        reset = 1'b0;
        stall = 1'b0;
        post(8'h3C, 1'b1);
        check("post_rst_t1_en", int'(sig_input_en), 0);
        tick;
        check("post_rst_t2_en", int'(sig_input_en), 1);
        check("post_rst_t2_data", int'(sig_input_data), 'h3C);
        drain(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
